f2h_packet_writer: RTL and testbench

- FPGA-side initiator for the f2h FIFO's external memory-mapped bridge interface (the fifo_f2h_in_mm_external_interface signal group).
- Takes a 32-bit Avalon-ST packet stream from fabric logic and converts each beat into bus writes to the FIFO's packet-mode write slave.
- Writes the other-info register (SOP/EOP/empty) when needed, then the data word.
- Counts beats and packets for debug.

---
 rtl/f2h_packet_writer.sv | 172 +++++++++++++++++
 tb/tb_f2h_packet_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2h_packet_writer.sv
// Avalon-ST to memory-mapped bridge writer for the f2h FIFO packet-mode slave.
// Each accepted beat becomes an optional other-info write followed by a data write.
module f2h_packet_writer #(
    parameter int unsigned COUNT_W             = 16,
    parameter bit          SKIP_REDUNDANT_INFO = 1'b1
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [1:0]         in_empty,
    output logic [2:0]         avm_address,
    output logic [3:0]         avm_byte_enable,
    output logic               avm_read,
    output logic               avm_write,
    output logic [31:0]        avm_write_data,
    input  logic               avm_acknowledge,
    input  logic [31:0]        avm_read_data,
    input  logic               stats_clear,
    output logic [COUNT_W-1:0] beat_count,
    output logic [COUNT_W-1:0] pkt_count,
    output logic               busy,
    output logic               protocol_err
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned EMPTY_W   = 2;
    localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_INFO = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE,
        INFO,
        GAP,
        DATA
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    state_t              state, state_nxt;
    beat_t               beat_q, beat_nxt;
    logic [DATA_W-1:0]   last_info, last_info_nxt;
    logic                info_valid, info_valid_nxt;
    logic                write_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [COUNT_W-1:0]  beat_count_nxt, pkt_count_nxt;
    logic                protocol_err_nxt;
    logic                handshake;
    logic                unused_read_data;

    // Other-info word: sop at bit 0, eop at bit 1, empty at bits 3:2 only on eop.
    function automatic logic [DATA_W-1:0] info_of(input beat_t b);
        info_of = {(DATA_W-4)'(0), (b.eop ? b.empty : EMPTY_W'(0)), b.eop, b.sop};
    endfunction

    assign in_ready         = (state == IDLE);
    assign handshake        = in_valid && in_ready;
    assign avm_byte_enable  = 4'hF;
    assign avm_read         = 1'b0;
    assign unused_read_data = ^avm_read_data;

    // Next-state, captured beat, counters and registered bus outputs.
    always_comb begin
        state_nxt        = state;
        beat_nxt         = beat_q;
        last_info_nxt    = last_info;
        info_valid_nxt   = info_valid;
        beat_count_nxt   = beat_count;
        pkt_count_nxt    = pkt_count;
        protocol_err_nxt = protocol_err;
        write_nxt        = 1'b0;
        addr_nxt         = ADDR_DATA;
        wdata_nxt        = '0;

        unique case (state)
            IDLE: begin
                if (handshake) begin
                    beat_nxt = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};
                    if (!SKIP_REDUNDANT_INFO || !info_valid || (info_of(beat_nxt) != last_info))
                        state_nxt = INFO;
                    else
                        state_nxt = DATA;
                end
            end
            INFO: begin
                if (avm_acknowledge) begin
                    last_info_nxt  = info_of(beat_q);
                    info_valid_nxt = 1'b1;
                    state_nxt      = GAP;
                end
            end
            GAP: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (avm_acknowledge) begin
                    beat_count_nxt = beat_count + COUNT_W'(1);
                    if (beat_q.eop)
                        pkt_count_nxt = pkt_count + COUNT_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // An acknowledge with no write outstanding is a slave protocol violation.
        if (avm_acknowledge && !avm_write)
            protocol_err_nxt = 1'b1;

        if (stats_clear) begin
            beat_count_nxt   = '0;
            pkt_count_nxt    = '0;
            protocol_err_nxt = 1'b0;
        end

        // Outputs are decoded from the next state so the write appears one cycle after the handshake.
        unique case (state_nxt)
            INFO: begin
                write_nxt = 1'b1;
                addr_nxt  = ADDR_INFO;
                wdata_nxt = info_of(beat_nxt);
            end
            DATA: begin
                write_nxt = 1'b1;
                addr_nxt  = ADDR_DATA;
                wdata_nxt = beat_nxt.data;
            end
            default: begin
                write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= IDLE;
            beat_q         <= '0;
            last_info      <= '0;
            info_valid     <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_write_data <= '0;
            beat_count     <= '0;
            pkt_count      <= '0;
            busy           <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            beat_q         <= beat_nxt;
            last_info      <= last_info_nxt;
            info_valid     <= info_valid_nxt;
            avm_write      <= write_nxt;
            avm_address    <= addr_nxt;
            avm_write_data <= wdata_nxt;
            beat_count     <= beat_count_nxt;
            pkt_count      <= pkt_count_nxt;
            busy           <= (state_nxt != IDLE);
            protocol_err   <= protocol_err_nxt;
        end
    end

endmodule

// File: tb/tb_f2h_packet_writer.sv
// Bench for f2h_packet_writer: table-driven beats, bus responder with scoreboard,
// and hand-written sequences for backpressure, stray acknowledge, reset and wrap.
module tb_f2h_packet_writer;

    logic        clk_clk         = 1'b0;
    logic        reset_reset_n   = 1'b0;
    logic [31:0] in_data         = '0;
    logic        in_valid        = 1'b0;
    logic        in_sop          = 1'b0;
    logic        in_eop          = 1'b0;
    logic [1:0]  in_empty        = '0;
    logic        avm_acknowledge = 1'b0;
    logic [31:0] avm_read_data   = '0;
    logic        stats_clear     = 1'b0;

    logic        in_ready, avm_read, avm_write, busy, protocol_err;
    logic [2:0]  avm_address;
    logic [3:0]  avm_byte_enable;
    logic [31:0] avm_write_data;
    logic [15:0] beat_count, pkt_count;

    logic        in_ready4, avm_read4, avm_write4, busy4, protocol_err4;
    logic [2:0]  avm_address4;
    logic [3:0]  avm_byte_enable4;
    logic [31:0] avm_write_data4;
    logic [3:0]  beat_count4, pkt_count4;

    f2h_packet_writer dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .avm_address(avm_address), .avm_byte_enable(avm_byte_enable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_write_data(avm_write_data),
        .avm_acknowledge(avm_acknowledge), .avm_read_data(avm_read_data),
        .stats_clear(stats_clear), .beat_count(beat_count), .pkt_count(pkt_count),
        .busy(busy), .protocol_err(protocol_err)
    );

    f2h_packet_writer #(.COUNT_W(4)) dut4 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .avm_address(avm_address4), .avm_byte_enable(avm_byte_enable4),
        .avm_read(avm_read4), .avm_write(avm_write4), .avm_write_data(avm_write_data4),
        .avm_acknowledge(avm_acknowledge), .avm_read_data(avm_read_data),
        .stats_clear(stats_clear), .beat_count(beat_count4), .pkt_count(pkt_count4),
        .busy(busy4), .protocol_err(protocol_err4)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        bit          eop;
        int          delay;
    } wr_t;

    typedef struct {
        bit          sop;
        bit          eop;
        logic [1:0]  empty;
        logic [31:0] data;
        bit          info_wr;
        logic [31:0] info;
    } vec_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_beat = 0;
    int          m_pkt  = 0;
    bit          m_iv   = 1'b0;
    logic [31:0] m_last = '0;
    bit          inject_ack   = 1'b0;
    bit          req_clear    = 1'b0;
    bit          clear_on_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Bus responder: acknowledges writes after the per-write delay and scores them.
    bit          in_xfer   = 1'b0;
    bit          prev_ack  = 1'b0;
    int          cnt       = 0;
    logic [2:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    always begin
        wr_t e;
        @(posedge clk_clk);
        #1;
        avm_acknowledge = 1'b0;
        stats_clear     = 1'b0;
        if (!reset_reset_n) begin
            in_xfer  = 1'b0;
            prev_ack = 1'b0;
            cnt      = 0;
        end else begin
            if (prev_ack)
                check("write_gap_after_ack", 32'(avm_write), 32'd0);
            prev_ack = 1'b0;
            if (avm_write) begin
                if (!in_xfer) begin
                    in_xfer   = 1'b1;
                    cnt       = 0;
                    hold_addr = avm_address;
                    hold_data = avm_write_data;
                end else begin
                    check("hold_address", 32'(avm_address), 32'(hold_addr));
                    check("hold_data", avm_write_data, hold_data);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h", avm_address, avm_write_data);
                    avm_acknowledge = 1'b1;
                    in_xfer  = 1'b0;
                    prev_ack = 1'b1;
                end else if (cnt >= exp_q[0].delay) begin
                    e = exp_q.pop_front();
                    avm_acknowledge = 1'b1;
                    check("write_address", 32'(avm_address), 32'(e.addr));
                    check("write_data", avm_write_data, e.data);
                    if (e.addr == 3'd0) begin
                        if (clear_on_ack) begin
                            stats_clear  = 1'b1;
                            clear_on_ack = 1'b0;
                            m_beat = 0;
                            m_pkt  = 0;
                        end else begin
                            m_beat++;
                            if (e.eop) m_pkt++;
                        end
                    end
                    in_xfer  = 1'b0;
                    prev_ack = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                if (inject_ack) begin
                    avm_acknowledge = 1'b1;
                    inject_ack      = 1'b0;
                end
                if (req_clear) begin
                    stats_clear = 1'b1;
                    req_clear   = 1'b0;
                    m_beat = 0;
                    m_pkt  = 0;
                end
            end
        end
    end

    task automatic send_beat_exp(input bit sop, input bit eop, input logic [1:0] empty,
                                 input logic [31:0] data, input int delay,
                                 input bit info_wr, input logic [31:0] info, output int waited);
        if (info_wr) begin
            exp_q.push_back('{addr: 3'd4, data: info, eop: 1'b0, delay: delay});
            m_last = info;
            m_iv   = 1'b1;
        end
        exp_q.push_back('{addr: 3'd0, data: data, eop: eop, delay: delay});
        in_sop   = sop;
        in_eop   = eop;
        in_empty = empty;
        in_data  = data;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 300) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("handshake_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
            check("write_latency", 32'(avm_write), 32'd1);
        end
    endtask

    task automatic send_beat(input bit sop, input bit eop, input logic [1:0] empty,
                             input logic [31:0] data, input int delay, output int waited);
        logic [31:0] info;
        info = {28'd0, (eop ? empty : 2'd0), eop, sop};
        send_beat_exp(sop, eop, empty, data, delay, (!m_iv || info != m_last), info, waited);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy || in_xfer) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_beat_count"}, 32'(beat_count), 32'(m_beat) & 32'hFFFF);
        check({tag, "_pkt_count"}, 32'(pkt_count), 32'(m_pkt) & 32'hFFFF);
        check({tag, "_pkt_count_w4"}, 32'(pkt_count4), 32'(m_pkt) & 32'hF);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_flag_clear(input string name);
        int n = 0;
        while ((inject_ack || req_clear) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check(name, 32'(inject_ack || req_clear), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   w;

        // Single-beat packet, then a 4-beat packet exercising the redundant-info skip.
        vecs[0] = '{sop: 1, eop: 1, empty: 2'd2, data: 32'hA5A5_0001, info_wr: 1, info: 32'h0000_000B};
        vecs[1] = '{sop: 1, eop: 0, empty: 2'd0, data: 32'h0000_0010, info_wr: 1, info: 32'h0000_0001};
        vecs[2] = '{sop: 0, eop: 0, empty: 2'd0, data: 32'h0000_0011, info_wr: 1, info: 32'h0000_0000};
        vecs[3] = '{sop: 0, eop: 0, empty: 2'd0, data: 32'h0000_0012, info_wr: 0, info: 32'h0000_0000};
        vecs[4] = '{sop: 0, eop: 1, empty: 2'd0, data: 32'h0000_0013, info_wr: 1, info: 32'h0000_0002};

        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_avm_write_data", avm_write_data, 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);
        check("byte_enable", 32'(avm_byte_enable), 32'hF);
        check("avm_read", 32'(avm_read), 32'd0);
        reset_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            send_beat_exp(vecs[i].sop, vecs[i].eop, vecs[i].empty, vecs[i].data, 0,
                          vecs[i].info_wr, vecs[i].info, w);
            if (i == 0) begin
                wait_idle();
                check_counts("single");
            end
        end
        wait_idle();
        check_counts("multi");

        // Acknowledge withheld for 20 cycles on a data write; the next beat must wait.
        send_beat(0, 1, 2'd0, 32'hDEAD_0003, 20, w);
        check("hold_in_ready_low", 32'(in_ready), 32'd0);
        send_beat(1, 1, 2'd1, 32'hBEEF_0004, 0, w);
        check("backpressure_wait", 32'(w >= 20), 32'd1);
        wait_idle();
        check_counts("backpressure");

        // Stray acknowledge in IDLE, then clear.
        inject_ack = 1'b1;
        wait_flag_clear("inject_timeout");
        tick();
        check("perr_set", 32'(protocol_err), 32'd1);
        check("perr_busy", 32'(busy), 32'd0);
        check("perr_in_ready", 32'(in_ready), 32'd1);
        repeat (3) tick();
        check("perr_sticky", 32'(protocol_err), 32'd1);
        req_clear = 1'b1;
        wait_flag_clear("clear_timeout");
        tick();
        check("perr_cleared", 32'(protocol_err), 32'd0);
        check_counts("cleared");

        // Reset while the info write is stalled.
        send_beat(1, 1, 2'd3, 32'h0000_0055, 10, w);
        check("info_pending_addr", 32'(avm_address), 32'd4);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("reset_drops_write", 32'(avm_write), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_iv   = 1'b0;
        m_last = '0;
        m_beat = 0;
        m_pkt  = 0;
        tick();
        tick();
        reset_reset_n = 1'b1;
        tick();
        send_beat(0, 0, 2'd0, 32'h0000_0066, 0, w);
        send_beat(0, 1, 2'd0, 32'h0000_0067, 0, w);
        wait_idle();
        check_counts("after_reset");

        // Counter wrap on the 4-bit instance, then clear coincident with a counting acknowledge.
        req_clear = 1'b1;
        wait_flag_clear("clear_timeout");
        tick();
        for (int i = 0; i < 17; i++) send_beat(1, 1, 2'd0, 32'h100 + 32'(i), 0, w);
        wait_idle();
        check_counts("wrap17");
        check("wrap_beat_count_w4", 32'(beat_count4), 32'd1);
        req_clear = 1'b1;
        wait_flag_clear("clear_timeout");
        tick();
        for (int i = 0; i < 16; i++) send_beat(1, 1, 2'd0, 32'h200 + 32'(i), 0, w);
        wait_idle();
        clear_on_ack = 1'b1;
        send_beat(1, 1, 2'd0, 32'h0000_0210, 0, w);
        wait_idle();
        check("clear_on_ack_consumed", 32'(clear_on_ack), 32'd0);
        check_counts("clear_wins");
        check("clear_wins_beat_w4", 32'(beat_count4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
